// File: rtl/regfile_scoreboard_decoder_if.sv
// regfile_scoreboard_decoder_if: issue/writeback/query bundle; master = pipeline side, slave = decoder side
interface regfile_scoreboard_decoder_if #(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic iss_ready;
  logic wb_valid;
  logic [ADDR_W-1:0] wb_rd;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic rs1_busy;
  logic rs2_busy;
  logic [DEPTH-1:0] wr_onehot;
  logic [DEPTH-1:0] busy_vec;
  logic [CNT_W-1:0] busy_cnt;
  logic err_wb_idle;
  modport master (
    output iss_valid, iss_rd, wb_valid, wb_rd, rs1_addr, rs2_addr,
    input iss_ready, rs1_busy, rs2_busy, wr_onehot, busy_vec, busy_cnt, err_wb_idle
  );
  modport slave (
    input iss_valid, iss_rd, wb_valid, wb_rd, rs1_addr, rs2_addr,
    output iss_ready, rs1_busy, rs2_busy, wr_onehot, busy_vec, busy_cnt, err_wb_idle
  );
endinterface

// File: rtl/regfile_scoreboard_decoder.sv
// regfile_scoreboard_decoder: writeback one-hot decode + busy scoreboard with bypassed rs1/rs2 hazard query; ports clk, rst, bus (slave: issue/writeback/query in; ready, busy, onehot, count, error out)
module regfile_scoreboard_decoder #(
  parameter int ADDR_W = 5,
  parameter int DEPTH = 32,
  parameter int ZERO_HARDWIRED = 1
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [DEPTH-1:0] KEEP = (ZERO_HARDWIRED != 0) ? ~DEPTH'(1) : '1;
  function automatic logic [DEPTH-1:0] dec(input logic [ADDR_W-1:0] a);
    return (DEPTH'(1) << a) & KEEP;
  endfunction
  logic [DEPTH-1:0] busy_q, busy_d, wr_q, iss_dec, wb_dec, rs1_dec, rs2_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, wb_hit, iss_fire, wb_x0;
  always_comb begin
    iss_dec = dec(bus.iss_rd);
    wb_dec = dec(bus.wb_rd);
    rs1_dec = dec(bus.rs1_addr);
    rs2_dec = dec(bus.rs2_addr);
    wb_hit = bus.wb_valid & (|(busy_q & wb_dec));
    wb_x0 = (ZERO_HARDWIRED != 0) && (bus.wb_rd == '0);
    bus.iss_ready = ~(|iss_dec) | ~(|(busy_q & iss_dec)) | (wb_hit & (bus.wb_rd == bus.iss_rd));
    iss_fire = bus.iss_valid & bus.iss_ready;
    busy_d = (busy_q & ~(bus.wb_valid ? wb_dec : '0)) | (iss_fire ? iss_dec : '0);
    err_d = bus.wb_valid & ~wb_hit & ~wb_x0;
    bus.rs1_busy = (|(busy_q & rs1_dec)) & ~(bus.wb_valid & (bus.wb_rd == bus.rs1_addr));
    bus.rs2_busy = (|(busy_q & rs2_dec)) & ~(bus.wb_valid & (bus.wb_rd == bus.rs2_addr));
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + CNT_W'(busy_d[i]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wr_q <= bus.wb_valid ? wb_dec : '0;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.busy_vec = busy_q;
  assign bus.wr_onehot = wr_q;
  assign bus.busy_cnt = cnt_q;
  assign bus.err_wb_idle = err_q;
endmodule
